mp_link_tx: RTL and testbench
=============================

// Module: mp_link_tx
// PURPOSE
//  Serial transmitter for the inter-board multiplayer link: sends local player state (score, pause, reload) to
//  the peer board over one wire, in place of six parallel wires. Sits after ctl_score/ctl_pause/ctl_reload.
//  Drives the pin the peer receiver samples. Sends on state change and as a periodic keepalive so the peer can
//  detect connection.
// PARAMETERS
//  BIT_CYCLES        564      clk cycles per bit (65 MHz / 115200 baud); legal range >=2
//  STOP_BITS         1        number of stop bits, 1 or 2
//  KEEPALIVE_CYCLES  650_000  idle cycles after last frame end before a keepalive frame is sent (10 ms)
// PORTS
//  clk         in   1  system clock, 65 MHz
//  rst         in   1  synchronous, active-high reset
//  score       in   4  local score, sampled at frame start
//  pause       in   1  local pause level, sampled at frame start
//  reload      in   1  local reload; may be a 1-cycle pulse, captured sticky
//  force_send  in   1  1-cycle request to send a frame regardless of change
//  tx          out  1  serial line, idle high
//  busy        out  1  high from first start-bit cycle to last stop-bit cycle inclusive
//  frame_done  out  1  1-cycle pulse on the cycle after the last stop-bit cycle
// BEHAVIOUR
//  - Reset values: tx=1, busy=0, frame_done=0; FSM=IDLE; reload_sticky=0; keepalive counter=0; send_pending=1.
//    The first frame is therefore sent right after reset is released.
//  - Frame, LSB first, each bit held exactly BIT_CYCLES: start(0), d0..d7, [parity], STOP_BITS x 1.
//    Data byte = {1'b1, 1'b0, reload_snap, pause_snap, score_snap[3:0]}. Bits 7:6 = 2'b10 is the sync marker.
//  - reload_sticky is set by any cycle with reload=1. It is cleared when a frame snapshots it at START entry.
//    A reload that occurs on the snapshot cycle stays set for the next frame; no reload is ever lost.
//  - Trigger sets send_pending:
//    - {score,pause} differs from the last snapshot
//    - reload_sticky=1
//    - force_send=1
//    - keepalive counter reaches KEEPALIVE_CYCLES-1 while IDLE (counter reset on frame_done and on any start).
//  - FSM: IDLE -> START (when send_pending; snapshot taken, send_pending cleared, same cycle)
//    -> DATA (8 bits) -> PARITY (if enabled) -> STOP (STOP_BITS bits) -> IDLE.
//    Transition IDLE->START is registered: tx falls 1 cycle after the triggering input.
//  - Triggers during a frame set send_pending. The next frame starts on the cycle after frame_done;
//    the line is idle high for exactly 1 cycle between back-to-back frames. Multiple triggers merge into one frame.
//  - Counters: baud counter 0..BIT_CYCLES-1, $clog2(BIT_CYCLES) bits. Bit index 0..7 wraps to 0 on frame end.
//    Keepalive counter saturates, no wrap.
//  - Inputs are not sampled mid-frame; changes during a frame only set send_pending.
//  - rst mid-frame: tx=1 on the next cycle, frame aborted, state as at reset; the frame restarts after release.
// CONFIGURATION
//  MP_LINK_PARITY_EN defined: one even-parity bit (XOR of d7..d0) is inserted after d7. Frame = 10+STOP_BITS bits.
//  MP_LINK_PARITY_EN undefined: no parity bit; frame = 9+STOP_BITS bits; PARITY state absent.
// TESTING  (BIT_CYCLES=4, STOP_BITS=1, KEEPALIVE_CYCLES=100, parity off unless noted)
//  - Reset release, score=4'h5, pause=0 -> tx low 1 cycle later; bits 0,1,0,1,0,0,0,0,1,1 (LSB first),
//    each 4 cycles; frame_done at cycle 41.
//  - After the first frame, inputs held for 100 idle cycles -> identical keepalive frame starts;
//    no frame starts before that.
//  - 1-cycle reload pulse while busy -> exactly one following frame has d5=1, starting 1 cycle after frame_done;
//    the subsequent keepalive has d5=0.
//  - score 3->4->5 during one frame -> exactly one extra frame, carrying score=5.
//  - rst asserted at bit 4 of a frame -> tx=1, busy=0 next cycle; a full frame restarts after release.
//  - MP_LINK_PARITY_EN, score=4'h7, pause=1 -> data 0x97, parity bit 1, frame_done after 44 cycles.

Source files
------------

// File: rtl/mp_link_tx.sv
// Serial transmitter for the inter-board multiplayer link: 8N1-style frames of local score/pause/reload.
// Define MP_LINK_PARITY_EN to insert an even-parity bit after d7.
module mp_link_tx #(
  parameter int BIT_CYCLES       = 564,
  parameter int STOP_BITS        = 1,
  parameter int KEEPALIVE_CYCLES = 650_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] score,
  input  logic       pause,
  input  logic       reload,
  input  logic       force_send,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int BAUD_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int KA_W   = (KEEPALIVE_CYCLES > 1) ? $clog2(KEEPALIVE_CYCLES) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BIT_CYCLES - 1);
  localparam logic [KA_W-1:0]   KA_LAST   = KA_W'(KEEPALIVE_CYCLES - 1);
  localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef MP_LINK_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t            state, state_next;
  logic [BAUD_W-1:0] baud_cnt, baud_next;
  logic [2:0]        bit_idx, bit_next;
  logic [7:0]        data_q, data_next;
  logic [KA_W-1:0]   ka_cnt, ka_next;
  logic              tx_next, done_next;
  logic              send_pending, pending_next;
  logic              reload_sticky, sticky_next;
  logic              bit_end, change, trig, go;

  // data_q doubles as the "last snapshot" used for change detection.
  assign bit_end = (baud_cnt == BAUD_LAST);
  assign change  = ({score, pause} != {data_q[3:0], data_q[4]});
  assign trig    = change | reload_sticky | force_send | ((state == S_IDLE) && (ka_cnt == KA_LAST));
  assign go      = (state == S_IDLE) && (send_pending || trig);

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_next   = state;
    baud_next    = baud_cnt;
    bit_next     = bit_idx;
    data_next    = data_q;
    tx_next      = tx;
    done_next    = 1'b0;
    pending_next = go ? 1'b0 : (send_pending | trig);
    sticky_next  = go ? reload : (reload_sticky | reload);
    if (state != S_IDLE || go)  ka_next = '0;
    else if (ka_cnt != KA_LAST) ka_next = ka_cnt + 1'b1;
    else                        ka_next = ka_cnt;

    case (state)
      S_IDLE: begin
        if (go) begin
          state_next = S_START;
          baud_next  = '0;
          tx_next    = 1'b0;
          data_next  = {2'b10, reload_sticky, pause, score};
        end
      end
      S_START: begin
        if (bit_end) begin
          state_next = S_DATA;
          baud_next  = '0;
          bit_next   = 3'd0;
          tx_next    = data_q[0];
        end else begin
          baud_next  = baud_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (!bit_end) begin
          baud_next = baud_cnt + 1'b1;
        end else if (bit_idx != 3'd7) begin
          baud_next = '0;
          bit_next  = bit_idx + 3'd1;
          tx_next   = data_q[bit_idx + 3'd1];
        end else begin
          baud_next = '0;
          bit_next  = 3'd0;
`ifdef MP_LINK_PARITY_EN
          state_next = S_PARITY;
          tx_next    = ^data_q;
`else
          state_next = S_STOP;
          tx_next    = 1'b1;
`endif
        end
      end
`ifdef MP_LINK_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_next = S_STOP;
          baud_next  = '0;
          bit_next   = 3'd0;
          tx_next    = 1'b1;
        end else begin
          baud_next  = baud_cnt + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (!bit_end) begin
          baud_next = baud_cnt + 1'b1;
        end else if (bit_idx != STOP_LAST) begin
          baud_next = '0;
          bit_next  = bit_idx + 3'd1;
        end else begin
          state_next = S_IDLE;
          baud_next  = '0;
          bit_next   = 3'd0;
          done_next  = 1'b1;
          tx_next    = 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      baud_cnt      <= '0;
      bit_idx       <= 3'd0;
      data_q        <= 8'h00;
      ka_cnt        <= '0;
      tx            <= 1'b1;
      frame_done    <= 1'b0;
      send_pending  <= 1'b1;
      reload_sticky <= 1'b0;
    end else begin
      state         <= state_next;
      baud_cnt      <= baud_next;
      bit_idx       <= bit_next;
      data_q        <= data_next;
      ka_cnt        <= ka_next;
      tx            <= tx_next;
      frame_done    <= done_next;
      send_pending  <= pending_next;
      reload_sticky <= sticky_next;
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_mp_link_tx.sv
// Directed self-checking bench for mp_link_tx (BIT_CYCLES=4, STOP_BITS=1, KEEPALIVE_CYCLES=100).
// Expectations follow MP_LINK_PARITY_EN when the bench is built with it.
module tb_mp_link_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] score = 4'h5;
  logic       pause = 1'b0;
  logic       reload = 1'b0;
  logic       force_send = 1'b0;
  logic       tx, busy, frame_done;

  int checks = 0;
  int failures = 0;

  mp_link_tx #(
    .BIT_CYCLES      (4),
    .STOP_BITS       (1),
    .KEEPALIVE_CYCLES(100)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .score     (score),
    .pause     (pause),
    .reload    (reload),
    .force_send(force_send),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish (got timeout, want completion)");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for the start bit, checks the idle lead-in length, then every bit of the frame
  // cycle by cycle; returns on the frame_done cycle.
  task automatic expect_frame(input string tag, input logic [7:0] byte_exp, input int lead_exp);
    logic [11:0] bits;
    logic [3:0]  w;
    logic        busy_all, done_any;
    int          lead, nb;
    bits    = '1;
    bits[0] = 1'b0;
    bits[8:1] = byte_exp;
`ifdef MP_LINK_PARITY_EN
    bits[9] = ^byte_exp;
    nb = 11;
`else
    nb = 10;
`endif
    lead = 0;
    while (tx !== 1'b0 && lead < 400) begin
      step();
      lead++;
    end
    check({tag, "_lead"}, lead, lead_exp);
    check({tag, "_start"}, tx, 1'b0);
    if (tx !== 1'b0) return;
    busy_all = 1'b1;
    done_any = 1'b0;
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < 4; k++) begin
        w[k] = tx;
        busy_all &= busy;
        done_any |= frame_done;
        step();
      end
      check($sformatf("%s_bit%0d", tag, b), w, bits[b] ? 4'hF : 4'h0);
    end
    check({tag, "_busy_during"}, busy_all, 1'b1);
    check({tag, "_done_early"}, done_any, 1'b0);
    check({tag, "_done"}, frame_done, 1'b1);
    check({tag, "_busy_after"}, busy, 1'b0);
    check({tag, "_tx_idle"}, tx, 1'b1);
  endtask

  initial begin
    step();
    step();
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", frame_done, 1'b0);

    // First frame right after reset release: 0x85, tx low one cycle later.
    rst = 1'b0;
    expect_frame("first", 8'h85, 1);

    // Keepalive after exactly 100 idle cycles with unchanged inputs.
    expect_frame("keepalive", 8'h85, 100);

    // force_send from idle, with a 1-cycle reload pulse mid-frame.
    fork
      begin
        repeat (12) @(posedge clk);
        #2 reload = 1'b1;
        @(posedge clk);
        #2 reload = 1'b0;
      end
    join_none
    force_send = 1'b1;
    step();
    force_send = 1'b0;
    expect_frame("force", 8'h85, 0);
    expect_frame("reload", 8'hA5, 1);
    expect_frame("ka_after_reload", 8'h85, 100);

    // Score 3 triggers a frame; 3->4->5 inside it merges into one extra frame.
    fork
      begin
        repeat (10) @(posedge clk);
        #2 score = 4'h4;
        repeat (10) @(posedge clk);
        #2 score = 4'h5;
      end
    join_none
    score = 4'h3;
    expect_frame("score3", 8'h83, 1);
    expect_frame("score5", 8'h85, 1);
    expect_frame("ka_after_score", 8'h85, 100);

    // Reset asserted at frame bit 4 (d3 of 0x85 = 0).
    force_send = 1'b1;
    step();
    force_send = 1'b0;
    repeat (16) step();
    check("mid_tx_bit4", tx, 1'b0);
    check("mid_busy", busy, 1'b1);
    rst = 1'b1;
    step();
    check("midrst_tx", tx, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", frame_done, 1'b0);
    step();
    rst = 1'b0;
    expect_frame("restart", 8'h85, 1);

    // score=7, pause=1 -> data 0x97 (parity bit 1 when enabled).
    score = 4'h7;
    pause = 1'b1;
    expect_frame("s7p1", 8'h97, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
